// File: rtl/gate_pkg.sv
// Shared types and constants for the gate interlock: leg states, leg indices,
// request codes and fault-cause bit positions.
package gate_pkg;

  localparam int NUM_LEGS = 4;

  typedef enum logic [3:0] {
    L_OFF  = 4'b0001,
    L_UP   = 4'b0010,
    L_DN   = 4'b0100,
    L_DEAD = 4'b1000
  } leg_state_t;

  localparam int LEG_BUCK1 = 0;
  localparam int LEG_BUCK2 = 1;
  localparam int LEG_RES1  = 2;
  localparam int LEG_RES2  = 3;

  localparam int CAUSE_SHORT = 0;
  localparam int CAUSE_MAXON = 1;
  localparam int CAUSE_TRIP  = 2;

  localparam logic [1:0] REQ_OFF   = 2'b00;
  localparam logic [1:0] REQ_DN    = 2'b01;
  localparam logic [1:0] REQ_UP    = 2'b10;
  localparam logic [1:0] REQ_SHORT = 2'b11;

  // Gate pins are a pure decode of the leg state, so 11 can never appear.
  function automatic logic [1:0] gate_decode(input leg_state_t s);
    logic [1:0] g;
    g = 2'b00;
    if (s == L_UP) g = REQ_UP;
    else if (s == L_DN) g = REQ_DN;
    return g;
  endfunction

endpackage

// File: rtl/gate_leg_fsm.sv
// One half-bridge leg: enforces dead time between any turn-off and the next
// turn-on, and bounds the continuous on-time of the upper switch.
module gate_leg_fsm
  import gate_pkg::*;
#(
  parameter logic [15:0] DEAD_TIME     = 16'd10,
  parameter logic [15:0] MAX_ON_CYCLES = 16'd1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       force_off,
  output logic [1:0] gate,
  output logic       up_on,
  output logic       viol_short,
  output logic       viol_maxon
);

  leg_state_t  state_reg, state_next;
  logic [15:0] on_cnt_reg, on_cnt_next;
  logic [15:0] dead_cnt_reg, dead_cnt_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= L_OFF;
      on_cnt_reg   <= 16'd0;
      dead_cnt_reg <= 16'd0;
    end else begin
      state_reg    <= state_next;
      on_cnt_reg   <= on_cnt_next;
      dead_cnt_reg <= dead_cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    viol_short = (req == REQ_SHORT);
    viol_maxon = 1'b0;
    case (state_reg)
      L_OFF: begin
        if (!force_off) begin
          if (req == REQ_UP) state_next = L_UP;
          else if (req == REQ_DN) state_next = L_DN;
        end
      end
      L_UP: begin
        if (req != REQ_UP || force_off) begin
          state_next = L_DEAD;
        end else if (on_cnt_reg >= MAX_ON_CYCLES - 16'd1) begin
          state_next = L_DEAD;
          viol_maxon = 1'b1;
        end
      end
      L_DN: begin
        if (req != REQ_DN || force_off) state_next = L_DEAD;
      end
      L_DEAD: begin
        if (dead_cnt_reg >= DEAD_TIME - 16'd1) state_next = L_OFF;
      end
      default: state_next = L_OFF;
    endcase
  end

  // Both counters restart on any state change and saturate instead of wrapping.
  always_comb begin
    on_cnt_next   = on_cnt_reg;
    dead_cnt_next = dead_cnt_reg;
    if (state_next != state_reg) begin
      on_cnt_next   = 16'd0;
      dead_cnt_next = 16'd0;
    end else begin
      if (state_reg == L_UP && on_cnt_reg != 16'hFFFF) on_cnt_next = on_cnt_reg + 16'd1;
      if (state_reg == L_DEAD && dead_cnt_reg != 16'hFFFF) dead_cnt_next = dead_cnt_reg + 16'd1;
    end
  end

  assign gate  = gate_decode(state_reg);
  assign up_on = (state_reg == L_UP);

endmodule

// File: rtl/gate_interlock.sv
// Safety stage between the discharge controller and the gate drivers: four
// interlocked legs, deion gating, and a sticky fault latch with a guarded clear.
module gate_interlock
  import gate_pkg::*;
#(
  parameter logic [15:0] DEAD_TIME     = 16'd10,
  parameter logic [15:0] MAX_ON_CYCLES = 16'd1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       arm,
  input  logic       trip,
  input  logic       fault_clr,
  input  logic [1:0] req_buck1,
  input  logic [1:0] req_buck2,
  input  logic [1:0] req_res1,
  input  logic [1:0] req_res2,
  input  logic       req_deion,
  output logic [1:0] gate_buck1,
  output logic [1:0] gate_buck2,
  output logic [1:0] gate_res1,
  output logic [1:0] gate_res2,
  output logic       gate_deion,
  output logic       fault,
  output logic [2:0] fault_cause,
  output logic [3:0] fault_leg
);

  logic [1:0]          req_leg  [NUM_LEGS];
  logic [1:0]          gate_leg [NUM_LEGS];
  logic [NUM_LEGS-1:0] up_on;
  logic [NUM_LEGS-1:0] viol_short;
  logic [NUM_LEGS-1:0] viol_maxon;
  logic [NUM_LEGS-1:0] req_idle;
  logic                force_off;

  logic                fault_reg, fault_next;
  logic [2:0]          cause_reg, cause_next;
  logic [3:0]          leg_reg, leg_next;
  logic                deion_reg, deion_next;
  logic [2:0]          new_cause;
  logic [3:0]          new_leg;
  logic                clear_ok;

  assign req_leg[LEG_BUCK1] = req_buck1;
  assign req_leg[LEG_BUCK2] = req_buck2;
  assign req_leg[LEG_RES1]  = req_res1;
  assign req_leg[LEG_RES2]  = req_res2;

  assign force_off = fault_reg | ~arm;

  generate
    for (genvar gi = 0; gi < NUM_LEGS; gi++) begin : g_leg
      gate_leg_fsm #(
        .DEAD_TIME    (DEAD_TIME),
        .MAX_ON_CYCLES(MAX_ON_CYCLES)
      ) u_leg (
        .clk       (clk),
        .rst       (rst),
        .req       (req_leg[gi]),
        .force_off (force_off),
        .gate      (gate_leg[gi]),
        .up_on     (up_on[gi]),
        .viol_short(viol_short[gi]),
        .viol_maxon(viol_maxon[gi])
      );
      assign req_idle[gi] = (req_leg[gi] == REQ_OFF);
    end
  endgenerate

  // A clear only takes effect when nothing could immediately re-arm a switch;
  // violations seen in the same cycle are still recorded.
  always_comb begin
    new_cause              = 3'b000;
    new_cause[CAUSE_SHORT] = |viol_short;
    new_cause[CAUSE_MAXON] = |viol_maxon;
    new_cause[CAUSE_TRIP]  = trip;
    new_leg                = viol_short | viol_maxon;
    clear_ok               = fault_clr & ~trip & (&req_idle) & ~req_deion;
    if (clear_ok) begin
      fault_next = |new_cause;
      cause_next = new_cause;
      leg_next   = new_leg;
    end else begin
      fault_next = fault_reg | (|new_cause);
      cause_next = cause_reg | new_cause;
      leg_next   = leg_reg | new_leg;
    end
    deion_next = req_deion & arm & ~fault_reg & ~(|up_on);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fault_reg <= 1'b0;
      cause_reg <= 3'b000;
      leg_reg   <= 4'b0000;
      deion_reg <= 1'b0;
    end else begin
      fault_reg <= fault_next;
      cause_reg <= cause_next;
      leg_reg   <= leg_next;
      deion_reg <= deion_next;
    end
  end

  assign gate_buck1  = gate_leg[LEG_BUCK1];
  assign gate_buck2  = gate_leg[LEG_BUCK2];
  assign gate_res1   = gate_leg[LEG_RES1];
  assign gate_res2   = gate_leg[LEG_RES2];
  assign gate_deion  = deion_reg;
  assign fault       = fault_reg;
  assign fault_cause = cause_reg;
  assign fault_leg   = leg_reg;

endmodule

// File: tb/tb_gate_interlock.sv
// Directed bench for gate_interlock: a countdown-based behavioural model checked
// every cycle, plus literal expectations at the key points of each scenario.
module tb_gate_interlock;

  localparam int DT  = 10;
  localparam int MAX = 1000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       arm = 1'b0;
  logic       trip = 1'b0;
  logic       fault_clr = 1'b0;
  logic [1:0] req_buck1 = 2'b00, req_buck2 = 2'b00, req_res1 = 2'b00, req_res2 = 2'b00;
  logic       req_deion = 1'b0;
  logic [1:0] gate_buck1, gate_buck2, gate_res1, gate_res2;
  logic       gate_deion, fault;
  logic [2:0] fault_cause;
  logic [3:0] fault_leg;

  int checks = 0;
  int errors = 0;

  gate_interlock #(.DEAD_TIME(16'd10), .MAX_ON_CYCLES(16'd1000)) dut (
    .clk(clk), .rst(rst), .arm(arm), .trip(trip), .fault_clr(fault_clr),
    .req_buck1(req_buck1), .req_buck2(req_buck2), .req_res1(req_res1), .req_res2(req_res2),
    .req_deion(req_deion),
    .gate_buck1(gate_buck1), .gate_buck2(gate_buck2), .gate_res1(gate_res1), .gate_res2(gate_res2),
    .gate_deion(gate_deion), .fault(fault), .fault_cause(fault_cause), .fault_leg(fault_leg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  // Model: each leg is either driving (m_gate), or off with a countdown of edges
  // (m_cool) before it may accept a new request; m_on counts cycles driven high.
  logic [1:0] m_gate [4];
  int         m_cool [4];
  int         m_on   [4];
  logic       m_fault, m_deion, m_valid = 1'b0;
  logic [2:0] m_cause;
  logic [3:0] m_leg;
  logic [1:0] r [4];
  logic       forced, any_up, clr_ok, nd;
  logic [3:0] sh, mx;
  logic [2:0] nc;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        m_gate[i] = 2'b00; m_cool[i] = 0; m_on[i] = 0;
      end
      m_fault = 1'b0; m_cause = 3'b000; m_leg = 4'b0000; m_deion = 1'b0; m_valid = 1'b1;
    end else begin
      r[0] = req_buck1; r[1] = req_buck2; r[2] = req_res1; r[3] = req_res2;
      forced = m_fault || !arm;
      any_up = 1'b0;
      for (int i = 0; i < 4; i++) if (m_gate[i] == 2'b10) any_up = 1'b1;
      nd = req_deion && arm && !m_fault && !any_up;
      sh = 4'b0000; mx = 4'b0000;
      for (int i = 0; i < 4; i++) begin
        sh[i] = (r[i] == 2'b11);
        if (m_gate[i] == 2'b10) begin
          if (r[i] != 2'b10 || forced) begin
            m_gate[i] = 2'b00; m_cool[i] = DT;
          end else if (m_on[i] == MAX) begin
            m_gate[i] = 2'b00; m_cool[i] = DT; mx[i] = 1'b1;
          end else m_on[i]++;
        end else if (m_gate[i] == 2'b01) begin
          if (r[i] != 2'b01 || forced) begin
            m_gate[i] = 2'b00; m_cool[i] = DT;
          end
        end else if (m_cool[i] > 0) begin
          m_cool[i]--;
        end else if (!forced && r[i] == 2'b10) begin
          m_gate[i] = 2'b10; m_on[i] = 1;
        end else if (!forced && r[i] == 2'b01) begin
          m_gate[i] = 2'b01;
        end
      end
      nc = {trip, |mx, |sh};
      clr_ok = fault_clr && !trip && (r[0] == 0) && (r[1] == 0) && (r[2] == 0) && (r[3] == 0) && !req_deion;
      if (clr_ok) begin
        m_fault = |nc; m_cause = nc; m_leg = sh | mx;
      end else begin
        m_fault = m_fault | (|nc); m_cause = m_cause | nc; m_leg = m_leg | sh | mx;
      end
      m_deion = nd;
    end
  end

  always @(negedge clk) begin
    if (m_valid)
      chk("cycle_outputs",
          {15'd0, gate_buck1, gate_buck2, gate_res1, gate_res2, gate_deion, fault, fault_cause, fault_leg},
          {15'd0, m_gate[0], m_gate[1], m_gate[2], m_gate[3], m_deion, m_fault, m_cause, m_leg});
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_clr();
    fault_clr = 1'b1;
    tick(1);
    fault_clr = 1'b0;
  endtask

  int ones;

  initial begin
    tick(3);
    chk("reset_fault", fault, 1'b0);
    chk("reset_gates", {gate_buck1, gate_buck2, gate_res1, gate_res2}, 8'h00);
    chk("reset_cause_leg", {fault_cause, fault_leg}, 7'd0);
    rst = 1'b0;
    tick(2);

    // Basic pass-through with one cycle of latency
    arm = 1'b1; req_buck1 = 2'b10;
    tick(1);
    chk("buck1_up_latency", gate_buck1, 2'b10);
    chk("buck1_up_nofault", fault, 1'b0);
    tick(5);

    // Direct swap: 11 cycles of 00, then the lower switch
    req_buck1 = 2'b01;
    for (int k = 1; k <= 11; k++) begin
      tick(1);
      chk("swap_dead", gate_buck1, 2'b00);
    end
    tick(1);
    chk("swap_dn_on", gate_buck1, 2'b01);
    req_buck1 = 2'b00;
    tick(15);

    // Upper-switch on-time limit
    req_res1 = 2'b10;
    ones = 0;
    for (int k = 0; k < 1200; k++) begin
      tick(1);
      if (gate_res1 == 2'b10) ones++;
    end
    chk("maxon_cycles", ones, 1000);
    chk("maxon_fault", fault, 1'b1);
    chk("maxon_cause", fault_cause, 3'b010);
    chk("maxon_leg", fault_leg, 4'b0100);
    req_res1 = 2'b00;
    tick(2);
    pulse_clr();
    chk("maxon_cleared", {fault, fault_cause, fault_leg}, 8'd0);
    tick(2);

    // Shoot-through request
    req_buck2 = 2'b11;
    tick(1);
    req_buck2 = 2'b00;
    chk("short_gate", gate_buck2, 2'b00);
    chk("short_fault", fault, 1'b1);
    chk("short_cause", fault_cause, 3'b001);
    chk("short_leg", fault_leg, 4'b0010);
    req_buck1 = 2'b01;
    pulse_clr();
    chk("clr_ignored", fault, 1'b1);
    chk("clr_ignored_gate", gate_buck1, 2'b00);
    req_buck1 = 2'b00;
    tick(1);
    pulse_clr();
    chk("clr_honoured", {fault, fault_cause, fault_leg}, 8'd0);
    tick(2);

    // External trip while the upper switch and deion are requested
    req_buck1 = 2'b10; req_deion = 1'b1;
    tick(3);
    chk("deion_blocked_by_up", gate_deion, 1'b0);
    trip = 1'b1;
    tick(1);
    trip = 1'b0;
    tick(DT + 1);
    chk("trip_gates_off", {gate_buck1, gate_buck2, gate_res1, gate_res2}, 8'h00);
    chk("trip_deion_off", gate_deion, 1'b0);
    chk("trip_cause", fault_cause, 3'b100);
    chk("trip_leg", fault_leg, 4'b0000);
    tick(20);
    chk("trip_held_off", gate_buck1, 2'b00);
    pulse_clr();
    chk("trip_clr_ignored", fault, 1'b1);
    req_buck1 = 2'b00; req_deion = 1'b0;
    tick(1);
    pulse_clr();
    chk("trip_cleared", fault, 1'b0);
    tick(2);

    // Disarm mid-pulse, then re-arm
    req_buck1 = 2'b10;
    tick(5);
    chk("pre_disarm_up", gate_buck1, 2'b10);
    arm = 1'b0;
    tick(1);
    chk("disarm_off", gate_buck1, 2'b00);
    chk("disarm_nofault", fault, 1'b0);
    tick(12);
    chk("disarm_held", gate_buck1, 2'b00);
    arm = 1'b1;
    tick(1);
    chk("rearm_up", gate_buck1, 2'b10);

    // Deion passes once no upper switch is on
    req_buck1 = 2'b00; req_deion = 1'b1;
    tick(3);
    chk("deion_on", gate_deion, 1'b1);
    req_deion = 1'b0;
    tick(15);

    // Reset mid-pulse
    req_buck1 = 2'b10;
    tick(2);
    chk("pre_reset_up", gate_buck1, 2'b10);
    rst = 1'b1;
    tick(1);
    chk("reset_mid_pulse", gate_buck1, 2'b00);
    rst = 1'b0;
    tick(3);
    req_buck1 = 2'b00;
    tick(15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gate_interlock.md
Name: gate_interlock

Overview:
- Downstream safety stage between the discharge-control FSM and the gate-driver pins.
- Takes requested gate pairs for buck1, buck2, res1 and res2, plus the deion request.
- Guarantees no shoot-through, a hardware-minimum dead time, and a bounded upper-switch on-time, independent of upstream logic.
- Any violation latches a fault, drives every gate off, and reports the cause.

Parameters:
- DEAD_TIME, 16'd10: minimum all-off cycles on a leg between any on→off and the next on (10 ns units).
- MAX_ON_CYCLES, 16'd1000: maximum continuous upper-switch on-time per leg before a forced trip.
- NUM_LEGS, 4: leg count; order is buck1, buck2, res1, res2. Fixed at 4 in this revision.

Ports:
- clk  in  1  100 MHz system clock
- rst  in  1  synchronous, active-high reset
- arm  in  1  1 = pass gates; 0 = all outputs off, no fault raised
- trip  in  1  external trip (overcurrent etc.), level-sensitive
- fault_clr  in  1  single-cycle fault clear request
- req_buck1, req_buck2, req_res1, req_res2  in  2 each  requested {up, down}
- req_deion  in  1  requested deion switch
- gate_buck1, gate_buck2, gate_res1, gate_res2  out  2 each  safe {up, down}
- gate_deion  out  1  safe deion gate
- fault  out  1  latched fault
- fault_cause  out  3  sticky cause: bit0 = 2'b11 request, bit1 = max-on exceeded, bit2 = external trip
- fault_leg  out  4  sticky bitmask of offending legs (bit0 = buck1 … bit3 = res2)

Behaviour:
- Single clock domain; reset is synchronous and active-high.
- Reset values: all gate outputs 0, fault 0, fault_cause 0, fault_leg 0, every leg FSM in L_OFF, all counters 0.
- All outputs are registered. Gate outputs decode the leg state register, so request-to-gate latency is 1 cycle.
- Per-leg FSM (states L_OFF, L_UP, L_DN, L_DEAD):
  - L_OFF, out 00: req 10 → L_UP; req 01 → L_DN; req 00 → stay.
  - L_UP, out 10: on_cnt increments each cycle.
    - req ≠ 10 → L_DEAD.
    - on_cnt reaches MAX_ON_CYCLES-1 while still requested → L_DEAD; set fault, cause bit1, leg bit.
  - L_DN, out 01: req ≠ 01 → L_DEAD. There is no on-time limit on the lower switch.
  - L_DEAD, out 00: dead_cnt counts 0..DEAD_TIME-1, then → L_OFF. Requests are ignored, except 11.
- A direct 10↔01 request swap therefore yields 00 for exactly DEAD_TIME cycles plus one L_OFF cycle before the new switch turns on.
- req 11 in any state: the leg goes to L_DEAD (or stays in L_OFF); set fault, cause bit0, leg bit.
- trip = 1: set fault and cause bit2 every cycle it is high.
- fault = 1 or arm = 0:
  - Legs in L_UP/L_DN go to L_DEAD.
  - Legs leaving L_DEAD return to L_OFF and remain there regardless of request.
- gate_deion = req_deion & arm & ~fault & no leg in L_UP. It is registered and has 1-cycle latency. Deion has no dead-time enforcement.
- fault_clr:
  - Honoured only when trip = 0, all leg requests are 00, and req_deion = 0. fault, fault_cause and fault_leg clear next cycle.
  - Otherwise it is ignored; there is no partial clear.
- Simultaneous events:
  - New violations in the same cycle as an honoured clear win: fault stays 1 and the new causes are recorded.
  - Multiple legs violating in one cycle set all corresponding leg bits.
- Counters: 16-bit, saturating, zeroed on every state entry.
- Reset mid-pulse: all gates drop to 0 in the cycle after rst is sampled. No dead-time hold is needed because every output goes to 0 together.

Decomposition:
- Shared package gate_pkg holds:
  - leg-state localparams (L_OFF, L_UP, L_DN, L_DEAD, one-hot 4-bit);
  - the leg index constants;
  - the fault_cause bit positions.
- Sub-module gate_leg_fsm, instantiated 4×:
  - ports: clk, rst, req[1:0], force_off, gate[1:0], up_on, viol_short, viol_maxon;
  - contains the FSM and both counters.
- The top holds the fault latch, deion gating and the clear logic.

Test Plan:
- Reset, then arm = 1, req_buck1 = 10 → gate_buck1 = 10 after 1 cycle, fault = 0.
- req_buck1 10 → 01 at cycle T → gate_buck1 = 00 for cycles T+1..T+11 and 01 at T+12; never 11.
- req_res1 held 10 for 1200 cycles → gate_res1 drops to 00 after 1000 cycles on; fault = 1, fault_cause = 3'b010, fault_leg = 4'b0100.
- req_buck2 = 11 for one cycle → gate_buck2 stays 00; fault = 1, cause = 3'b001, leg = 4'b0010. fault_clr with req_buck1 = 01 is ignored; with all requests 00 it clears next cycle.
- trip pulse while buck1 = 10 and req_deion = 1 → all gates 00 within DEAD_TIME+1 cycles, gate_deion = 0, cause = 3'b100. Legs stay 00 with requests active until a legal clear.
- arm = 0 mid-pulse → legs go through L_DEAD to 00 with fault = 0. Re-arm with req 10 → gate 10 after 1 cycle once the leg is back in L_OFF.
